imm_gen_pipe: RTL

Pipelined, parametrised immediate generator and branch-target unit for the decode stage. Accepts one instruction word plus PC per cycle over a valid/ready handshake. Produces the XLEN-wide immediate, a format code, an illegal flag and the PC-relative target one cycle later. A two-entry skid buffer gives full throughput under back-pressure. It sits between fetch and the register-file read and execute stages, and supports RV32 and RV64 operation through a single parameter.

---
 rtl/imm_gen_pipe.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator and PC-relative target unit.
// Each instruction word is decoded in the accept cycle. The finished result
// is then stored in a two-entry buffer: an output register plus a skid
// register. ready_o comes straight from a flop, so the upstream handshake
// has no combinational path from ready_i.

module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     insn_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_o
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_SH   = 3'd7
    } fmt_e;

    // One fully decoded entry, as held in either buffer slot
    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;

    logic signed [11:0] raw_i;
    logic signed [11:0] raw_s;
    logic signed [12:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [20:0] raw_j;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] imm_sh;

    fmt_e            raw_fmt;
    logic            raw_illegal;
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            pc_relative;
    logic [XLEN-1:0] dec_target;
    entry_t          incoming;

    assign opcode = insn_i[6:0];
    assign funct3 = insn_i[14:12];

    // Each immediate field is gathered into a signed vector. Casting that
    // vector to XLEN bits then sign-extends it from insn[31].
    assign raw_i = insn_i[31:20];
    assign raw_s = {insn_i[31:25], insn_i[11:7]};
    assign raw_b = {insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
    assign raw_u = {insn_i[31:12], 12'b0};
    assign raw_j = {insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

    assign imm_i = XLEN'(raw_i);
    assign imm_s = XLEN'(raw_s);
    assign imm_b = XLEN'(raw_b);
    assign imm_u = XLEN'(raw_u);
    assign imm_j = XLEN'(raw_j);
    assign imm_z = XLEN'(insn_i[19:15]);

    // A 6-bit shamt exists only for OP-IMM on RV64; every other shift uses 5 bits
    always_comb begin
        imm_sh = XLEN'(insn_i[24:20]);
        if (RV64 && (opcode == OPC_OP_IMM)) begin
            imm_sh = XLEN'(insn_i[25:20]);
        end
    end

    // Classify the instruction into a format and flag unsupported encodings
    always_comb begin
        raw_fmt     = FMT_NONE;
        raw_illegal = 1'b0;
        unique case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if ((opcode == OPC_OP_IMM_32) && !RV64) begin
                    raw_illegal = 1'b1;
                end else if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    raw_fmt = FMT_SH;
                    if (!(RV64 && (opcode == OPC_OP_IMM)) && insn_i[25]) begin
                        raw_illegal = 1'b1;
                    end
                end else begin
                    raw_fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: raw_fmt = FMT_I;
            OPC_STORE:          raw_fmt = FMT_S;
            OPC_BRANCH:         raw_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: raw_fmt = FMT_U;
            OPC_JAL:            raw_fmt = FMT_J;
            OPC_SYSTEM: begin
                if (funct3 == 3'b100) begin
                    raw_illegal = 1'b1;
                end else if (funct3[2]) begin
                    raw_fmt = FMT_Z;
                end else begin
                    raw_fmt = FMT_NONE;
                end
            end
            default: raw_illegal = 1'b1;
        endcase
        if (insn_i[1:0] != 2'b11) begin
            raw_illegal = 1'b1;
        end
    end

    // Illegal entries fall back to the NONE format, which yields a zero immediate
    always_comb begin
        dec_fmt = raw_illegal ? FMT_NONE : raw_fmt;
        unique case (dec_fmt)
            FMT_I:   dec_imm = imm_i;
            FMT_S:   dec_imm = imm_s;
            FMT_B:   dec_imm = imm_b;
            FMT_U:   dec_imm = imm_u;
            FMT_J:   dec_imm = imm_j;
            FMT_Z:   dec_imm = imm_z;
            FMT_SH:  dec_imm = imm_sh;
            default: dec_imm = '0;
        endcase
    end

    // Branches, JAL and AUIPC add the immediate to the PC; everything else gets pc+4
    always_comb begin
        pc_relative = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) ||
                      ((dec_fmt == FMT_U) && (opcode == OPC_AUIPC));
        dec_target  = pc_i + (pc_relative ? dec_imm : XLEN'(4));
    end

    // Pack the decoded fields into one buffer entry
    always_comb begin
        incoming.imm     = dec_imm;
        incoming.fmt     = dec_fmt;
        incoming.illegal = raw_illegal;
        incoming.target  = dec_target;
        incoming.pc      = pc_i;
    end

    // ------------------------------------------------------------------
    // Two-entry output buffer
    // ------------------------------------------------------------------
    entry_t or_q;
    entry_t sk_q;
    logic   or_valid;
    logic   sk_valid;
    logic   ready_q;

    logic   accept;
    logic   drain;
    logic   or_valid_next;
    logic   sk_valid_next;
    logic   load_or_new;
    logic   load_or_sk;
    logic   load_sk;

    assign accept = valid_i & ready_q;
    assign drain  = or_valid & ready_i;

    // Decide where a new entry lands and how the slots shift on a drain.
    // ready_q always mirrors an empty skid slot, so a new entry can never
    // arrive while the skid entry is moving forward.
    always_comb begin
        or_valid_next = or_valid;
        sk_valid_next = sk_valid;
        load_or_new   = 1'b0;
        load_or_sk    = 1'b0;
        load_sk       = 1'b0;
        if (drain && sk_valid) begin
            load_or_sk    = 1'b1;
            sk_valid_next = 1'b0;
        end else if (accept && (!or_valid || drain)) begin
            load_or_new   = 1'b1;
            or_valid_next = 1'b1;
        end else if (accept) begin
            load_sk       = 1'b1;
            sk_valid_next = 1'b1;
        end else if (drain) begin
            or_valid_next = 1'b0;
        end
    end

    // Occupancy flags and registered ready; reset outranks flush, and flush outranks traffic
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            ready_q  <= 1'b1;
        end else if (flush_i) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            or_valid <= or_valid_next;
            sk_valid <= sk_valid_next;
            ready_q  <= ~sk_valid_next;
        end
    end

    // Output register payload: refilled from the skid slot first, otherwise from the decoder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q <= '0;
        end else if (!flush_i) begin
            if (load_or_sk) begin
                or_q <= sk_q;
            end else if (load_or_new) begin
                or_q <= incoming;
            end
        end
    end

    // Skid register payload: captures an entry that arrives while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sk_q <= '0;
        end else if (!flush_i && load_sk) begin
            sk_q <= incoming;
        end
    end

    assign valid_o   = or_valid;
    assign ready_o   = ready_q;
    assign imm_o     = or_q.imm;
    assign fmt_o     = or_q.fmt;
    assign illegal_o = or_q.illegal;
    assign target_o  = or_q.target;
    assign pc_o      = or_q.pc;

endmodule
